serial_link_arbiter: RTL and testbench

- Round-robin arbiter that shares one serializer output link among N_CHANNELS independent val/rdy word streams.
- Each grant is held for exactly one burst of N_SAMPLES accepted words. This keeps each sample frame contiguous on the link.
- Sits between several serializer instances (requesters) and the single downstream SERDES transmit path.
- Tags each outgoing word with its source channel and marks the last word of every burst.

---
 rtl/serial_link_arbiter.sv | 177 +++++++++++++++++
 tb/tb_serial_link_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_arbiter.sv
// rtl/serial_link_arbiter.sv - round-robin burst arbiter sharing one serial link among several word streams
//
// Purpose:
//   Grants the downstream link to one requesting channel at a time. A grant
//   lasts for exactly N_SAMPLES accepted words, so that every sample frame
//   stays contiguous on the link. Between bursts the arbiter spends one IDLE
//   cycle choosing the next channel. The search starts at a rotating priority
//   pointer, which moves to the channel after the one that just finished.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   reset      - synchronous, active-high reset
//   recv_msg   - flattened request words; channel c at [c*BIT_WIDTH +: BIT_WIDTH]
//   recv_val   - per-channel valid
//   recv_rdy   - per-channel ready (only the granted channel ever sees send_rdy)
//   send_msg   - word forwarded to the link
//   send_val   - link valid
//   send_rdy   - link ready
//   send_chan  - source channel of send_msg
//   send_last  - high while the final word of a burst is presented

module serial_link_arbiter #(
  parameter int BIT_WIDTH  = 32,
  parameter int N_CHANNELS = 4,
  parameter int N_SAMPLES  = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_CHANNELS*BIT_WIDTH-1:0]  recv_msg,
  input  logic [N_CHANNELS-1:0]            recv_val,
  output logic [N_CHANNELS-1:0]            recv_rdy,
  output logic [BIT_WIDTH-1:0]             send_msg,
  output logic                             send_val,
  input  logic                             send_rdy,
  output logic [$clog2(N_CHANNELS)-1:0]    send_chan,
  output logic                             send_last
);

  localparam int GW = $clog2(N_CHANNELS);
  localparam int CW = $clog2(N_SAMPLES) + 1;

  localparam logic [CW-1:0] LAST_CNT = CW'(N_SAMPLES - 1);
  localparam logic [GW-1:0] LAST_CH  = GW'(N_CHANNELS - 1);
  localparam logic [GW:0]   NCH      = (GW + 1)'(N_CHANNELS);

  generate
    if (N_CHANNELS < 2) begin : g_bad_nch
      $error("serial_link_arbiter: N_CHANNELS must be at least 2");
    end
    if (N_SAMPLES < 1) begin : g_bad_nsamp
      $error("serial_link_arbiter: N_SAMPLES must be at least 1");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q,   ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Per-channel view of the flattened request bus.
  logic [BIT_WIDTH-1:0] chan_msg [N_CHANNELS];

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_unpack
    assign chan_msg[g] = recv_msg[g*BIT_WIDTH +: BIT_WIDTH];
  end

  // Rotate the request vector so that bit 0 is the channel at ptr_q. The
  // lowest set bit is then the distance from ptr_q to the winner.
  logic [2*N_CHANNELS-1:0] req_dbl;
  logic [N_CHANNELS-1:0]   req_rot;
  logic                    pick_found;
  logic [GW-1:0]           pick_off;
  logic [GW:0]             pick_sum;
  logic [GW-1:0]           pick_idx;

  assign req_dbl = {recv_val, recv_val};
  assign req_rot = N_CHANNELS'(req_dbl >> ptr_q);

  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    // Scan from the far end so the nearest requester is the last one written.
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_found = 1'b1;
        pick_off   = GW'(i);
      end
    end
  end

  // ptr + offset, wrapped modulo N_CHANNELS. This also works when
  // N_CHANNELS is not a power of two.
  always_comb begin
    pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
    if (pick_sum >= NCH) begin
      pick_idx = GW'(pick_sum - NCH);
    end else begin
      pick_idx = GW'(pick_sum);
    end
  end

  logic xfer;
  logic at_last;

  assign at_last = (count_q == LAST_CNT);
  assign xfer    = (state_q == BURST) && recv_val[grant_q] && send_rdy;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          count_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        // The grant is held until the frame completes. A stalled requester
        // only pauses the count and never gives up the link.
        if (xfer) begin
          if (at_last) begin
            state_d = IDLE;
            count_d = '0;
            ptr_d   = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    send_val  = 1'b0;
    send_msg  = '0;
    send_chan = '0;
    send_last = 1'b0;
    recv_rdy  = '0;
    if (state_q == BURST) begin
      send_val           = recv_val[grant_q];
      send_msg           = chan_msg[grant_q];
      send_chan          = grant_q;
      send_last          = at_last;
      recv_rdy[grant_q]  = send_rdy;
    end
  end

endmodule

// File: tb/tb_serial_link_arbiter.sv
// tb/tb_serial_link_arbiter.sv - self-checking bench for serial_link_arbiter

module tb_serial_link_arbiter;

  localparam int BW = 32;
  localparam int NC = 4;
  localparam int NS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic              reset;
  logic [BW-1:0]     msg_a [NC];
  logic [NC*BW-1:0]  recv_msg;
  logic [NC-1:0]     recv_val;
  logic [NC-1:0]     recv_rdy;
  logic [BW-1:0]     send_msg;
  logic              send_val;
  logic              send_rdy;
  logic [1:0]        send_chan;
  logic              send_last;

  assign recv_msg = {msg_a[3], msg_a[2], msg_a[1], msg_a[0]};

  serial_link_arbiter #(.BIT_WIDTH(BW), .N_CHANNELS(NC), .N_SAMPLES(NS)) dut (
    .clk       (clk),
    .reset     (reset),
    .recv_msg  (recv_msg),
    .recv_val  (recv_val),
    .recv_rdy  (recv_rdy),
    .send_msg  (send_msg),
    .send_val  (send_val),
    .send_rdy  (send_rdy),
    .send_chan (send_chan),
    .send_last (send_last)
  );

  // Small instance: two channels, single-word frames
  logic              s_reset;
  logic [BW-1:0]     s_msg_a [2];
  logic [2*BW-1:0]   s_recv_msg;
  logic [1:0]        s_recv_val;
  logic [1:0]        s_recv_rdy;
  logic [BW-1:0]     s_send_msg;
  logic              s_send_val;
  logic              s_send_rdy;
  logic [0:0]        s_send_chan;
  logic              s_send_last;

  assign s_recv_msg = {s_msg_a[1], s_msg_a[0]};

  serial_link_arbiter #(.BIT_WIDTH(BW), .N_CHANNELS(2), .N_SAMPLES(1)) dut2 (
    .clk       (clk),
    .reset     (s_reset),
    .recv_msg  (s_recv_msg),
    .recv_val  (s_recv_val),
    .recv_rdy  (s_recv_rdy),
    .send_msg  (s_send_msg),
    .send_val  (s_send_val),
    .send_rdy  (s_send_rdy),
    .send_chan (s_send_chan),
    .send_last (s_send_last)
  );

  wire [39:0] obs  = {send_val, send_chan, send_last, recv_rdy, send_msg};
  wire [36:0] obs2 = {s_send_val, s_send_chan, s_send_last, s_recv_rdy, s_send_msg};

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    recv_val = '0;
    send_rdy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic rand_msgs();
    for (int c = 0; c < NC; c++) msg_a[c] = $urandom;
  endtask

  task automatic test_reset();
    logic [39:0] exp;
    reset    = 1'b1;
    recv_val = 4'b1111;
    send_rdy = 1'b1;
    rand_msgs();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (obs !== 40'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", obs, 40'd0);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 40'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got %h expected %h", obs, 40'd0);
    end
    tick();
    @(negedge clk);
    exp = {1'b1, 2'd0, 1'b0, 4'b0001, msg_a[0]};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL first_grant_ch0: got %h expected %h", obs, exp);
    end
    do_reset();
  endtask

  task automatic test_single_ch1();
    logic [39:0] exp;
    do_reset();
    rand_msgs();
    recv_val = 4'b0010;
    send_rdy = 1'b1;
    msg_a[1] = 32'h10;
    @(negedge clk);
    checks++;
    if (obs !== 40'd0) begin
      errors++;
      $display("FAIL single_arb_cycle: got %h expected %h", obs, 40'd0);
    end
    tick();
    for (int i = 0; i < NS; i++) begin
      rand_msgs();
      msg_a[1] = 32'h10 + 32'(i);
      @(negedge clk);
      exp = {1'b1, 2'd1, 1'(i == NS - 1), 4'b0010, 32'h10 + 32'(i)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_word%0d: got %h expected %h", i, obs, exp);
      end
      tick();
    end
    recv_val = '0;
    @(negedge clk);
    checks++;
    if (obs !== 40'd0) begin
      errors++;
      $display("FAIL single_after_burst: got %h expected %h", obs, 40'd0);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [39:0] exp;
    int ph, ch;
    do_reset();
    recv_val = 4'b1111;
    send_rdy = 1'b1;
    for (int t = 0; t < 5 * (NS + 1); t++) begin
      rand_msgs();
      @(negedge clk);
      ph = t % (NS + 1);
      ch = (t / (NS + 1)) % NC;
      if (ph == 0) exp = 40'd0;
      else exp = {1'b1, 2'(ch), 1'(ph == NS), 4'(1 << ch), msg_a[2'(ch)]};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL round_robin t=%0d: got %h expected %h", t, obs, exp);
      end
      tick();
    end
    recv_val = '0;
  endtask

  task automatic test_rdy_toggle();
    logic [39:0] exp;
    int w;
    do_reset();
    rand_msgs();
    recv_val = 4'b0001;
    send_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 40'd0) begin
      errors++;
      $display("FAIL toggle_arb_cycle: got %h expected %h", obs, 40'd0);
    end
    tick();
    for (int t = 0; t < 2 * NS; t++) begin
      w = t / 2;
      send_rdy = 1'(t % 2);
      msg_a[0] = 32'hA0 + 32'(w);
      @(negedge clk);
      exp = {1'b1, 2'd0, 1'(w == NS - 1), {3'b000, send_rdy}, 32'hA0 + 32'(w)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL toggle t=%0d: got %h expected %h", t, obs, exp);
      end
      tick();
    end
    recv_val = '0;
    @(negedge clk);
    checks++;
    if (obs !== 40'd0) begin
      errors++;
      $display("FAIL toggle_done: got %h expected %h", obs, 40'd0);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [39:0] exp;
    int w;
    do_reset();
    rand_msgs();
    recv_val = 4'b1100;
    send_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 40'd0) begin
      errors++;
      $display("FAIL stall_arb_cycle: got %h expected %h", obs, 40'd0);
    end
    tick();
    for (int t = 0; t < NS + 3; t++) begin
      w = (t < 4) ? t : (t > 6) ? t - 3 : 4;
      recv_val[2] = !(t >= 4 && t <= 6);
      msg_a[2] = 32'h200 + 32'(w);
      msg_a[3] = $urandom;
      @(negedge clk);
      exp = {recv_val[2], 2'd2, 1'(w == NS - 1), 4'b0100, 32'h200 + 32'(w)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stall t=%0d: got %h expected %h", t, obs, exp);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (obs !== 40'd0) begin
      errors++;
      $display("FAIL stall_bubble: got %h expected %h", obs, 40'd0);
    end
    tick();
    @(negedge clk);
    exp = {1'b1, 2'd3, 1'b0, 4'b1000, msg_a[3]};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL stall_next_ch3: got %h expected %h", obs, exp);
    end
    tick();
    recv_val = '0;
  endtask

  task automatic test_reset_mid();
    logic [39:0] exp;
    do_reset();
    rand_msgs();
    recv_val = 4'b0100;
    send_rdy = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      msg_a[2] = 32'h300 + 32'(i);
      if (i == 2) reset = 1'b1;
      @(negedge clk);
      exp = {1'b1, 2'd2, 1'b0, 4'b0100, 32'h300 + 32'(i)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL midreset_word%0d: got %h expected %h", i, obs, exp);
      end
      tick();
    end
    reset    = 1'b0;
    recv_val = 4'b1001;
    @(negedge clk);
    checks++;
    if (obs !== 40'd0) begin
      errors++;
      $display("FAIL midreset_after: got %h expected %h", obs, 40'd0);
    end
    tick();
    for (int i = 0; i < NS; i++) begin
      rand_msgs();
      @(negedge clk);
      exp = {1'b1, 2'd0, 1'(i == NS - 1), 4'b0001, msg_a[0]};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL midreset_ch0_word%0d: got %h expected %h", i, obs, exp);
      end
      tick();
    end
    tick();
    @(negedge clk);
    exp = {1'b1, 2'd3, 1'b0, 4'b1000, msg_a[3]};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL midreset_then_ch3: got %h expected %h", obs, exp);
    end
    tick();
    recv_val = '0;
  endtask

  task automatic test_small();
    logic [36:0] exp;
    int c;
    s_reset    = 1'b1;
    s_recv_val = 2'b00;
    s_send_rdy = 1'b1;
    tick();
    tick();
    s_reset    = 1'b0;
    s_recv_val = 2'b11;
    for (int t = 0; t < 12; t++) begin
      s_msg_a[0] = $urandom;
      s_msg_a[1] = $urandom;
      @(negedge clk);
      c = (t / 2) % 2;
      if (t % 2 == 0) exp = 37'd0;
      else exp = {1'b1, 1'(c), 1'b1, 2'(1 << c), s_msg_a[1'(c)]};
      checks++;
      if (obs2 !== exp) begin
        errors++;
        $display("FAIL small t=%0d: got %h expected %h", t, obs2, exp);
      end
      tick();
    end
    s_recv_val = 2'b00;
  endtask

  // Reference model: a frame owner, the words already delivered, and the next
  // priority channel. Outputs follow from those values.
  task automatic test_random();
    logic [39:0] exp;
    logic [3:0]  rdy;
    bit m_busy;
    int m_owner, m_sent, m_prio, c;
    bit found;
    do_reset();
    m_busy = 0; m_owner = 0; m_sent = 0; m_prio = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(99) == 0);
      for (int k = 0; k < NC; k++) recv_val[k] = ($urandom_range(9) < 7);
      rand_msgs();
      send_rdy = ($urandom_range(3) != 0);
      @(negedge clk);
      if (!m_busy) begin
        exp = 40'd0;
      end else begin
        rdy = 4'b0000;
        if (send_rdy) rdy[2'(m_owner)] = 1'b1;
        exp = {recv_val[2'(m_owner)], 2'(m_owner), 1'(m_sent == NS - 1), rdy, msg_a[2'(m_owner)]};
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random n=%0d: got %h expected %h", n, obs, exp);
      end
      if (reset) begin
        m_busy = 0; m_sent = 0; m_prio = 0;
      end else if (!m_busy) begin
        found = 0;
        for (int k = 0; k < NC; k++) begin
          c = (m_prio + k) % NC;
          if (!found && recv_val[2'(c)]) begin
            found = 1; m_busy = 1; m_owner = c; m_sent = 0;
          end
        end
      end else if (recv_val[2'(m_owner)] && send_rdy) begin
        m_sent++;
        if (m_sent == NS) begin
          m_busy = 0;
          m_sent = 0;
          m_prio = (m_owner + 1) % NC;
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    recv_val   = '0;
    send_rdy   = 1'b0;
    s_reset    = 1'b1;
    s_recv_val = '0;
    s_send_rdy = 1'b0;
    for (int c = 0; c < NC; c++) msg_a[c] = '0;
    s_msg_a[0] = '0;
    s_msg_a[1] = '0;
    test_reset();
    test_single_ch1();
    test_round_robin();
    test_rdy_toggle();
    test_stall();
    test_reset_mid();
    test_small();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
